// File: rtl/phase_time_setter.sv
// phase_time_setter: pushbutton front end for the traffic-light countdown.
// Debounces MODE/UP/DOWN, walks RUN -> SET0 -> SET1 -> SET2 -> RUN on MODE,
// and edits the selected 7-bit phase duration with UP/DOWN (with auto-repeat).
// The packed durations t and the enSet hold signal feed the countdown block.
module phase_time_setter #(
  parameter int DEB_CYCLES = 500000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_RATE   = 5000000,
  parameter int T_MIN      = 1,
  parameter int T_MAX      = 99,
  parameter int DEF_T0     = 30,
  parameter int DEF_T1     = 25,
  parameter int DEF_T2     = 5
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        btnMode,
  input  logic        btnUp,
  input  logic        btnDown,
  output logic [20:0] t,
  output logic        enSet,
  output logic [1:0]  editSel
);

  // Debounce counter only has to reach DEB_CYCLES-1.
  localparam int DCW = $clog2(DEB_CYCLES) + 1;
  // Repeat counter only has to reach the larger of the two repeat intervals.
  localparam int RMX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RCW = $clog2(RMX + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SET0 = 2'd1,
    ST_SET1 = 2'd2,
    ST_SET2 = 2'd3
  } state_t;

  // Button index: 0 = MODE, 1 = UP, 2 = DOWN.
  logic [2:0]     w_raw;
  logic [2:0]     r_sync1;
  logic [2:0]     r_sync2;
  logic [2:0]     r_deb;
  logic [2:0]     r_deb_d;
  logic [DCW-1:0] r_deb_cnt [3];

  // Repeat index: 0 = UP, 1 = DOWN.
  logic [RCW-1:0] r_rep_cnt [2];
  logic [1:0]     r_rep_armed;

  logic [2:0]     w_press;
  logic [1:0]     w_rep;
  logic           w_mode_ev;
  logic           w_up_ev;
  logic           w_dn_ev;

  state_t         r_state;
  logic           r_en_set;
  logic [1:0]     r_edit_sel;
  logic [6:0]     r_t0;
  logic [6:0]     r_t1;
  logic [6:0]     r_t2;

  // Wrapping step helpers; out-of-range values fall back into [T_MIN,T_MAX].
  function automatic logic [6:0] f_inc(input logic [6:0] v);
    f_inc = (v >= 7'(T_MAX)) ? 7'(T_MIN) : v + 7'd1;
  endfunction

  function automatic logic [6:0] f_dec(input logic [6:0] v);
    f_dec = (v <= 7'(T_MIN)) ? 7'(T_MAX) : v - 7'd1;
  endfunction

  assign w_raw = {btnDown, btnUp, btnMode};

  // Two-flop synchronizer and per-button debounce: level flips only after
  // DEB_CYCLES consecutive samples that disagree with the current level.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press pulses on debounced rising edges; repeats fire once the hold counter
  // hits the first delay, then every REP_RATE cycles while still held.
  assign w_press = r_deb & ~r_deb_d;
  always_comb begin
    w_rep = '0;
    for (int j = 0; j < 2; j++) begin
      w_rep[j] = r_deb[j+1] &&
                 (r_rep_armed[j] ? (r_rep_cnt[j] == RCW'(REP_RATE))
                                 : (r_rep_cnt[j] == RCW'(REP_DELAY)));
    end
  end
  assign w_mode_ev = w_press[0];
  assign w_up_ev   = w_press[1] | w_rep[0];
  assign w_dn_ev   = w_press[2] | w_rep[1];

  // Hold counters for UP/DOWN; cleared on release and on any MODE event.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_rep_armed <= '0;
      for (int j = 0; j < 2; j++) r_rep_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!r_deb[j+1] || w_mode_ev) begin
          r_rep_cnt[j]   <= '0;
          r_rep_armed[j] <= 1'b0;
        end else if (w_rep[j]) begin
          r_rep_cnt[j]   <= RCW'(1);
          r_rep_armed[j] <= 1'b1;
        end else begin
          r_rep_cnt[j]   <= r_rep_cnt[j] + 1'b1;
        end
      end
    end
  end

  // Mode FSM with registered enSet/editSel and the editable duration fields.
  // MODE beats UP/DOWN; UP and DOWN together cancel; RUN freezes t.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= ST_RUN;
      r_en_set   <= 1'b0;
      r_edit_sel <= 2'b00;
      r_t0       <= 7'(DEF_T0);
      r_t1       <= 7'(DEF_T1);
      r_t2       <= 7'(DEF_T2);
    end else if (w_mode_ev) begin
      case (r_state)
        ST_RUN: begin
          r_state    <= ST_SET0;
          r_en_set   <= 1'b1;
          r_edit_sel <= 2'b00;
        end
        ST_SET0: begin
          r_state    <= ST_SET1;
          r_en_set   <= 1'b1;
          r_edit_sel <= 2'b01;
        end
        ST_SET1: begin
          r_state    <= ST_SET2;
          r_en_set   <= 1'b1;
          r_edit_sel <= 2'b11;
        end
        default: begin
          r_state    <= ST_RUN;
          r_en_set   <= 1'b0;
          r_edit_sel <= 2'b00;
        end
      endcase
    end else if ((r_state != ST_RUN) && (w_up_ev ^ w_dn_ev)) begin
      case (r_state)
        ST_SET0: r_t0 <= w_up_ev ? f_inc(r_t0) : f_dec(r_t0);
        ST_SET1: r_t1 <= w_up_ev ? f_inc(r_t1) : f_dec(r_t1);
        ST_SET2: r_t2 <= w_up_ev ? f_inc(r_t2) : f_dec(r_t2);
        default: ;
      endcase
    end
  end

  assign t       = {r_t0, r_t1, r_t2};
  assign enSet   = r_en_set;
  assign editSel = r_edit_sel;

endmodule

// File: tb/tb_phase_time_setter.sv
// Self-checking bench for phase_time_setter with short debounce/repeat timing.
module tb_phase_time_setter;

  localparam int DEB  = 4;
  localparam int RD   = 20;
  localparam int RR   = 5;
  localparam int TMIN = 1;
  localparam int TMAX = 99;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        btnMode = 1'b0;
  logic        btnUp = 1'b0;
  logic        btnDown = 1'b0;
  logic [20:0] t;
  logic        enSet;
  logic [1:0]  editSel;

  int checks = 0;
  int failures = 0;

  // Reference model: three durations and mode index (0 RUN, 1..3 SET0..SET2).
  int m_t[3];
  int m_state;

  phase_time_setter #(
    .DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_RATE(RR),
    .T_MIN(TMIN), .T_MAX(TMAX), .DEF_T0(30), .DEF_T1(25), .DEF_T2(5)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .btnMode(btnMode), .btnUp(btnUp),
    .btnDown(btnDown), .t(t), .enSet(enSet), .editSel(editSel)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [23:0] exp_out();
    logic [1:0] sel;
    case (m_state)
      2: sel = 2'b01;
      3: sel = 2'b11;
      default: sel = 2'b00;
    endcase
    return {7'(m_t[0]), 7'(m_t[1]), 7'(m_t[2]), (m_state != 0) ? 1'b1 : 1'b0, sel};
  endfunction

  task automatic model_reset();
    m_t[0] = 30; m_t[1] = 25; m_t[2] = 5;
    m_state = 0;
  endtask

  // mask = {down, up, mode}; h = cycles the raw buttons are held high.
  task automatic model_op(input logic [2:0] mask, input int h);
    int steps;
    int idx;
    if (h < DEB) return;
    if (mask[0]) begin
      m_state = (m_state + 1) % 4;
      return;
    end
    if (m_state == 0 || mask[1] == mask[2]) return;
    steps = 1 + (((h - 1) >= RD) ? 1 + (h - 1 - RD) / RR : 0);
    idx = m_state - 1;
    repeat (steps) begin
      if (mask[1]) m_t[idx] = (m_t[idx] == TMAX) ? TMIN : m_t[idx] + 1;
      else         m_t[idx] = (m_t[idx] == TMIN) ? TMAX : m_t[idx] - 1;
    end
  endtask

  task automatic drive(input logic [2:0] mask, input int h);
    @(negedge CLK);
    {btnDown, btnUp, btnMode} = mask;
    repeat (h) @(negedge CLK);
    {btnDown, btnUp, btnMode} = 3'b000;
    repeat (DEB + 4) @(negedge CLK);
    model_op(mask, h);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RSTn = 1'b0;
    {btnDown, btnUp, btnMode} = 3'b000;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    model_reset();
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    model_reset();
    checks++;
    if ({t, enSet, editSel} !== {7'd30, 7'd25, 7'd5, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL reset_defaults: got %h want %h", {t, enSet, editSel},
               {7'd30, 7'd25, 7'd5, 1'b0, 2'b00});
    end
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset_mid_edit();
    do_reset();
    drive(3'b001, DEB + 1);
    drive(3'b001, DEB + 1);
    drive(3'b010, DEB + 1);
    checks++;
    if (t[13:7] !== 7'd26 || editSel !== 2'b01) begin
      failures++;
      $display("FAIL mid_edit_setup: t1=%0d sel=%b want 26 01", t[13:7], editSel);
    end
    @(negedge CLK);
    #2 RSTn = 1'b0;
    #1;
    checks++;
    if ({t, enSet, editSel} !== {7'd30, 7'd25, 7'd5, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL async_reset: got %h want %h", {t, enSet, editSel},
               {7'd30, 7'd25, 7'd5, 1'b0, 2'b00});
    end
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    model_reset();
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if (enSet !== 1'b0) begin
        failures++;
        $display("FAIL bounce_early: cycle %0d enSet=%b want 0", i, enSet);
      end
      btnMode = (((i / 2) % 2) == 0);
    end
    // Stable high first sampled at edge k (i=8); no change through k+DEB+1.
    for (int i = 0; i < DEB + 1; i++) begin
      @(negedge CLK);
      checks++;
      if (enSet !== 1'b0) begin
        failures++;
        $display("FAIL bounce_latency_early: step %0d enSet=%b want 0", i, enSet);
      end
    end
    @(negedge CLK);
    checks++;
    if (enSet !== 1'b1 || editSel !== 2'b00) begin
      failures++;
      $display("FAIL bounce_transition: enSet=%b sel=%b want 1 00", enSet, editSel);
    end
    btnMode = 1'b0;
    repeat (DEB + 4) @(negedge CLK);
    m_state = 1;
    checks++;
    if ({t, enSet, editSel} !== exp_out()) begin
      failures++;
      $display("FAIL bounce_single: got %h want %h", {t, enSet, editSel}, exp_out());
    end
  endtask

  task automatic test_run_edit();
    do_reset();
    drive(3'b001, DEB + 1);
    drive(3'b010, DEB + 1);
    checks++;
    if (t[20:14] !== 7'd31 || {t, enSet, editSel} !== exp_out()) begin
      failures++;
      $display("FAIL set0_up: t0=%0d want 31 (all %h want %h)", t[20:14],
               {t, enSet, editSel}, exp_out());
    end
    repeat (3) drive(3'b001, DEB + 1);
    drive(3'b010, DEB + 1);
    checks++;
    if (t !== {7'd31, 7'd25, 7'd5} || enSet !== 1'b0) begin
      failures++;
      $display("FAIL run_frozen: t=%h enSet=%b want %h 0", t, enSet,
               {7'd31, 7'd25, 7'd5});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (3) drive(3'b001, DEB + 1);
    for (int i = 0; i < 4; i++) begin
      drive(3'b100, DEB + 1);
      checks++;
      if (t[6:0] !== 7'(4 - i)) begin
        failures++;
        $display("FAIL down_step%0d: t2=%0d want %0d", i, t[6:0], 4 - i);
      end
    end
    drive(3'b100, DEB + 1);
    checks++;
    if (t[6:0] !== 7'd99) begin
      failures++;
      $display("FAIL down_wrap: t2=%0d want 99", t[6:0]);
    end
    drive(3'b010, DEB + 1);
    checks++;
    if (t[6:0] !== 7'd1 || {t, enSet, editSel} !== exp_out()) begin
      failures++;
      $display("FAIL up_wrap: t2=%0d want 1", t[6:0]);
    end
  endtask

  task automatic test_autorepeat();
    do_reset();
    repeat (2) drive(3'b001, DEB + 1);
    drive(3'b010, 36);
    checks++;
    if (t[13:7] !== 7'd30 || {t, enSet, editSel} !== exp_out()) begin
      failures++;
      $display("FAIL autorepeat: t1=%0d want 30", t[13:7]);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(3'b001, DEB + 1);
    drive(3'b011, DEB + 1);
    checks++;
    if (editSel !== 2'b01 || t[20:14] !== 7'd30) begin
      failures++;
      $display("FAIL mode_beats_up: sel=%b t0=%0d want 01 30", editSel, t[20:14]);
    end
    drive(3'b110, 30);
    checks++;
    if (t !== {7'd30, 7'd25, 7'd5} || {t, enSet, editSel} !== exp_out()) begin
      failures++;
      $display("FAIL up_down_cancel: t=%h want %h", t, {7'd30, 7'd25, 7'd5});
    end
  endtask

  task automatic test_mode_cycle();
    logic [2:0] exp_tab [4];
    exp_tab[0] = 3'b100; exp_tab[1] = 3'b101; exp_tab[2] = 3'b111; exp_tab[3] = 3'b000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(3'b001, DEB + 2);
      checks++;
      if ({enSet, editSel} !== exp_tab[i]) begin
        failures++;
        $display("FAIL mode_cycle%0d: en/sel=%b want %b", i, {enSet, editSel}, exp_tab[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] mask;
    int h;
    int kind;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin mask = 3'b001; h = $urandom_range(DEB, RD - 1); end
        1: begin mask = 3'b010; h = $urandom_range(DEB, 45); end
        2: begin mask = 3'b100; h = $urandom_range(DEB, 45); end
        3: begin mask = 3'b110; h = $urandom_range(DEB, 45); end
        4: begin mask = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b101;
                 h = $urandom_range(DEB, RD - 1); end
        default: begin mask = 3'($urandom_range(1, 7)); h = $urandom_range(1, DEB - 1); end
      endcase
      drive(mask, h);
      checks++;
      if ({t, enSet, editSel} !== exp_out()) begin
        failures++;
        $display("FAIL random_op%0d mask=%b h=%0d: got %h want %h", n, mask, h,
                 {t, enSet, editSel}, exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_run_edit();
    test_wrap();
    test_autorepeat();
    test_simultaneous();
    test_mode_cycle();
    test_reset_mid_edit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
